sparce_skip_sequencer: RTL and testbench

Controller for the SparCE sparsity-skip path. It tracks which architectural registers currently hold zero, holds a small software-programmed SASA (Sparsity-Aware Skip Address) table, and matches each instruction PC entering execute against that table. On a hit whose sparsity condition holds, it issues a one-cycle `skipping` request with a registered `sparce_target` to fetch. It sits on the sparce side of `sparce_pipeline_if`, between pipeline writeback/execute and the fetch redirect logic.

---
 rtl/sparce_skip_sequencer.sv | 114 +++++++++++
 tb/tb_sparce_skip_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sparce_skip_sequencer.sv
// rtl/sparce_skip_sequencer.sv - SparCE skip sequencer: SASA table lookup, sparsity tracking, skip redirect FSM
// Optional feature macro: SPARCE_WB_BYPASS_EN (forward same-cycle writeback into cond evaluation)
module sparce_skip_sequencer #(
    parameter int          SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_BASE    = 32'h0000_1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic        if_ex_enable,
    input  logic        wb_en,
    input  logic [4:0]  rd,
    input  logic [31:0] wb_data,
    input  logic        sasa_wen,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    output logic        skipping,
    output logic [31:0] sparce_target
);
    localparam int IDX_W = $clog2(SASA_ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_WAIT} state_t;

    state_t             state, state_next;
    logic [31:0]        word0 [SASA_ENTRIES];
    logic [31:0]        word1 [SASA_ENTRIES];
    logic [31:0]        sprf;
    logic [31:0]        sprf_eff;
    logic [31:0]        trig_pc;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [31:0]        win_w1;
    logic               cond_true;
    logic               cfg_hit;
    logic [IDX_W-1:0]   cfg_idx;
    logic               unused_bits;

    assign cfg_hit     = sasa_wen && (sasa_addr[31:3+IDX_W] == SASA_BASE[31:3+IDX_W]);
    assign cfg_idx     = sasa_addr[3 +: IDX_W];
    assign win_w1      = word1[hit_idx];
    assign unused_bits = ^{sasa_addr[1:0], win_w1[19:12]};

    always_comb begin
        sprf_eff = sprf;
`ifdef SPARCE_WB_BYPASS_EN
        if (wb_en && rd != 5'd0) begin
            sprf_eff[rd] = (wb_data == 32'd0);
        end
`endif
    end

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (word1[i][21:20] != 2'b00 && word1[i][11:0] != 12'd0 && word0[i] == pc) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (win_w1[21:20])
            2'b01:   cond_true = sprf_eff[win_w1[31:27]];
            2'b10:   cond_true = sprf_eff[win_w1[31:27]] | sprf_eff[win_w1[26:22]];
            2'b11:   cond_true = sprf_eff[win_w1[31:27]] & sprf_eff[win_w1[26:22]];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (if_ex_enable && hit && cond_true) state_next = S_SKIP;
            S_SKIP:  state_next = S_WAIT;
            S_WAIT:  if (if_ex_enable && pc != trig_pc) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            skipping      <= 1'b0;
            sparce_target <= 32'd0;
            trig_pc       <= 32'd0;
            sprf          <= 32'h0000_0001;
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                word0[i] <= 32'd0;
                word1[i] <= 32'd0;
            end
        end else begin
            state    <= state_next;
            skipping <= (state_next == S_SKIP);
            if (state == S_IDLE && state_next == S_SKIP) begin
                sparce_target <= word0[hit_idx] + {18'd0, win_w1[11:0], 2'b00};
                trig_pc       <= pc;
            end
            if (wb_en && rd != 5'd0) begin
                sprf[rd] <= (wb_data == 32'd0);
            end
            if (cfg_hit) begin
                if (sasa_addr[2]) begin
                    word1[cfg_idx] <= sasa_data;
                end else begin
                    word0[cfg_idx] <= sasa_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_sparce_skip_sequencer.sv
// tb/tb_sparce_skip_sequencer.sv - directed vector table plus randomized model check for sparce_skip_sequencer
module tb_sparce_skip_sequencer;
`ifdef SPARCE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pc = '0;
    logic        if_ex_enable = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] wb_data = '0;
    logic        sasa_wen = 1'b0;
    logic [31:0] sasa_addr = '0;
    logic [31:0] sasa_data = '0;
    logic        skipping;
    logic [31:0] sparce_target;

    int n_checks = 0;
    int n_pass   = 0;

    sparce_skip_sequencer dut (
        .CLK(CLK), .RST(RST), .pc(pc), .if_ex_enable(if_ex_enable),
        .wb_en(wb_en), .rd(rd), .wb_data(wb_data),
        .sasa_wen(sasa_wen), .sasa_addr(sasa_addr), .sasa_data(sasa_data),
        .skipping(skipping), .sparce_target(sparce_target)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        bit          en;
        logic [31:0] pc;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          sw;
        logic [31:0] sa;
        logic [31:0] sd;
        bit          es;
        logic [31:0] et;
    } vec_t;

    vec_t vecs[$];

    // Reference model: table contents, zero flags, and "pulse pending / waiting for a new pc" flags.
    logic [31:0] m_w0 [16];
    logic [31:0] m_w1 [16];
    logic [31:0] m_sprf;
    bit          m_skip, m_wait;
    logic [31:0] m_tgt, m_trig;

    function automatic bit zero_of(int r);
        if (r == 0) return 1'b1;
        if (BYP && wb_en && int'(rd) == r) return (wb_data == 32'd0);
        return m_sprf[r];
    endfunction

    task automatic model_step();
        bit nskip = 1'b0;
        int win = -1;
        if (RST) begin
            for (int i = 0; i < 16; i++) begin m_w0[i] = 0; m_w1[i] = 0; end
            m_sprf = 32'h1; m_skip = 0; m_wait = 0; m_tgt = 0; m_trig = 0;
            return;
        end
        if (m_skip) m_wait = 1'b1;
        else if (m_wait) begin
            if (if_ex_enable && pc != m_trig) m_wait = 1'b0;
        end else if (if_ex_enable) begin
            for (int i = 0; i < 16; i++) begin
                if (m_w1[i][21:20] != 0 && m_w1[i][11:0] != 0 && m_w0[i] == pc) begin
                    win = i;
                    break;
                end
            end
            if (win >= 0) begin
                bit a = zero_of(int'(m_w1[win][31:27]));
                bit b = zero_of(int'(m_w1[win][26:22]));
                int c = int'(m_w1[win][21:20]);
                bit ok = (c == 1) ? a : (c == 2) ? (a | b) : (a & b);
                if (ok) begin
                    nskip  = 1'b1;
                    m_tgt  = m_w0[win] + 32'(m_w1[win][11:0]) * 32'd4;
                    m_trig = pc;
                end
            end
        end
        if (sasa_wen && (sasa_addr >> 7) == (32'h1000 >> 7)) begin
            int idx = int'((sasa_addr >> 3) & 32'hF);
            if (sasa_addr[2]) m_w1[idx] = sasa_data;
            else m_w0[idx] = sasa_data;
        end
        if (wb_en && rd != 0) m_sprf[rd] = (wb_data == 32'd0);
        m_skip = nskip;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(bit r, bit e, logic [31:0] p, bit we, logic [4:0] d, logic [31:0] wd,
                       bit sw, logic [31:0] sa, logic [31:0] sdat);
        RST = r; if_ex_enable = e; pc = p; wb_en = we; rd = d; wb_data = wd;
        sasa_wen = sw; sasa_addr = sa; sasa_data = sdat;
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic row(bit r, bit e, logic [31:0] p, bit we, logic [4:0] d, logic [31:0] wd,
                       bit sw, logic [31:0] sa, logic [31:0] sdat, bit es, logic [31:0] et);
        vec_t v;
        v.rst = r; v.en = e; v.pc = p; v.we = we; v.rd = d; v.wd = wd;
        v.sw = sw; v.sa = sa; v.sd = sdat; v.es = es; v.et = et;
        vecs.push_back(v);
    endtask

    task automatic nop(bit es, logic [31:0] et);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, es, et);
    endtask

    task automatic look(logic [31:0] p, bit es, logic [31:0] et);
        row(0, 1, p, 0, 0, 0, 0, 0, 0, es, et);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] dt, logic [31:0] et);
        row(0, 0, 0, 0, 0, 0, 1, a, dt, 0, et);
    endtask

    initial begin
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wr(32'h1000, 32'h200, 0);
        wr(32'h1004, 32'h2810_0004, 0);
        row(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        look(32'h200, 1, 32'h210);
        look(32'h200, 0, 32'h210);
        look(32'h200, 0, 32'h210);
        look(32'h200, 0, 32'h210);
        look(32'h204, 0, 32'h210);
        look(32'h200, 1, 32'h210);
        nop(0, 32'h210);
        row(0, 0, 0, 1, 5, 7, 0, 0, 0, 0, 32'h210);
        look(32'h204, 0, 32'h210);
        look(32'h200, 0, 32'h210);
        row(0, 1, 32'h204, 1, 5, 0, 0, 0, 0, 0, 32'h210);
        look(32'h200, 1, 32'h210);
        nop(0, 32'h210);
        look(32'h204, 0, 32'h210);
        wr(32'h1010, 32'h300, 32'h210);
        wr(32'h1014, 32'h2810_0001, 32'h210);
        wr(32'h1028, 32'h300, 32'h210);
        wr(32'h102C, 32'h2810_0008, 32'h210);
        look(32'h300, 1, 32'h304);
        nop(0, 32'h304);
        look(32'h204, 0, 32'h304);
        row(0, 0, 0, 1, 5, 9, 0, 0, 0, 0, 32'h304);
        row(0, 1, 32'h200, 1, 5, 0, 0, 0, 0, BYP, BYP ? 32'h210 : 32'h304);
        nop(0, BYP ? 32'h210 : 32'h304);
        look(32'h204, 0, BYP ? 32'h210 : 32'h304);
        look(32'h200, 1, 32'h210);
        nop(0, 32'h210);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        look(32'h200, 0, 0);
        wr(32'h1000, 32'hFFFF_FFF0, 0);
        wr(32'h1004, 32'h0010_0008, 0);
        look(32'hFFFF_FFF0, 1, 32'h10);
        nop(0, 32'h10);
        wr(32'h1080, 32'h400, 32'h10);
        look(32'h204, 0, 32'h10);
        look(32'h400, 0, 32'h10);
        look(32'hFFFF_FFF0, 1, 32'h10);
        nop(0, 32'h10);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].pc, vecs[i].we, vecs[i].rd, vecs[i].wd,
                vecs[i].sw, vecs[i].sa, vecs[i].sd);
            chk($sformatf("vec%0d_skipping", i), 32'(skipping), 32'(vecs[i].es));
            chk($sformatf("vec%0d_target", i), sparce_target, vecs[i].et);
        end

        begin
            logic [31:0] pcs [5];
            pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h300; pcs[3] = 32'h304; pcs[4] = 32'h400;
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int n = 0; n < 3000; n++) begin
                bit          r   = ($urandom_range(0, 199) == 0);
                bit          e   = ($urandom_range(0, 3) != 0);
                bit          we  = $urandom_range(0, 1);
                bit          sw  = ($urandom_range(0, 3) == 0);
                logic [4:0]  d   = 5'($urandom_range(0, 3));
                logic [31:0] wd  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
                logic [31:0] sa  = 32'h1000 + 32'($urandom_range(0, 3)) * 8 + 32'($urandom_range(0, 1)) * 4;
                logic [31:0] sdt;
                if ($urandom_range(0, 15) == 0) sa = sa + 32'h80;
                if (sa[2])
                    sdt = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
                           8'($urandom), 12'($urandom_range(0, 3))};
                else
                    sdt = pcs[$urandom_range(0, 4)];
                cyc(r, e, pcs[$urandom_range(0, 4)], we, d, wd, sw, sa, sdt);
                chk($sformatf("rnd%0d_skipping", n), 32'(skipping), 32'(m_skip));
                chk($sformatf("rnd%0d_target", n), sparce_target, m_tgt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
